// File: rtl/bus_dev_fifo.sv
// Per-device bus endpoint: TX FIFO (device -> bus) and RX FIFO (bus -> device), both FWFT.
// Optional destination-ID filtering on the RX side is enabled by defining ADDR_FILTER_EN.
module bus_dev_fifo #(
  parameter int unsigned PCKG_SZ   = 16,
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  DEV_ID    = 8'h00,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  input  logic               rx_rd,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic               rx_empty,
  output logic               tx_ovf,
  output logic               rx_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKG_SZ-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      tx_wr_ptr_q, tx_rd_ptr_q;
  logic [CW-1:0]      tx_count_q, tx_count_d;
  logic               tx_ovf_q;
  logic               tx_do_wr, tx_do_rd, tx_drop;

  always_comb begin
    tx_do_rd = pop && (tx_count_q != '0);
    // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
    tx_do_wr = tx_wr && ((tx_count_q != FULL_CNT) || tx_do_rd);
    tx_drop  = tx_wr && !tx_do_wr;
    tx_count_d = tx_count_q;
    case ({tx_do_wr, tx_do_rd})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      tx_ovf_q    <= 1'b0;
    end else begin
      if (tx_do_wr) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_do_rd) tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      tx_count_q <= tx_count_d;
      if (tx_drop) tx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKG_SZ-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CW-1:0]      rx_count_q, rx_count_d;
  logic               rx_ovf_q;
  logic               rx_id_hit, rx_addr_ok, rx_req;
  logic               rx_do_wr, rx_do_rd, rx_drop;

  always_comb begin
    rx_id_hit  = (D_push[PCKG_SZ-1 -: 8] == DEV_ID) || (D_push[PCKG_SZ-1 -: 8] == BROADCAST);
    rx_addr_ok = FILTER_EN ? rx_id_hit : 1'b1;
    // Filtered-out pushes never count as overflow.
    rx_req   = push && rx_addr_ok;
    rx_do_rd = rx_rd && (rx_count_q != '0);
    rx_do_wr = rx_req && ((rx_count_q != FULL_CNT) || rx_do_rd);
    rx_drop  = rx_req && !rx_do_wr;
    rx_count_d = rx_count_q;
    case ({rx_do_wr, rx_do_rd})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      if (rx_do_wr) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_do_rd) rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      rx_count_q <= rx_count_d;
      if (rx_drop) rx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_wr) rx_mem[rx_wr_ptr_q] <= D_push;
  end

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only
  // ---------------------------------------------------------------------------
  assign pndng    = (tx_count_q != '0);
  assign tx_full  = (tx_count_q == FULL_CNT);
  assign D_pop    = pndng ? tx_mem[tx_rd_ptr_q] : '0;
  assign rx_empty = (rx_count_q == '0);
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
  assign tx_ovf   = tx_ovf_q;
  assign rx_ovf   = rx_ovf_q;

endmodule
